// File: rtl/i_fetch.sv
`default_nettype none
// ============================================================================
// Module      : i_fetch
// Description : Instruction-fetch stage. Owns the PC, fetches from imem over a
//               single-outstanding req/ready handshake and drives the IF/ID
//               register consumed by i_decode. Accepts redirects and stalls
//               from the ID stage.
// Optional    : IFETCH_PERF_EN adds fetch/stall/squash performance counters.
// Ports       : clk, rst_n (async, active low)
//               reg_lock       - global freeze (IF/ID, PC, FSM hold)
//               reg_lock_if    - ID bubble request (IF/ID, PC hold)
//               jump_or_branch - redirect request, target = new PC
//               imem_req/imem_addr/imem_ready/imem_rdata - imem handshake
//               instruction/pc_plus_four/if_valid         - IF/ID register
//               fetch_count/stall_count/squash_count      - perf (optional)
// Revision    : 1.0 - initial release
// ============================================================================
module i_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0015
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_lock,
    input  logic        reg_lock_if,
    input  logic        jump_or_branch,
    input  logic [31:0] target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus_four,
    output logic        if_valid
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
    output logic [31:0] squash_count
`endif
);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] redir_pc, redir_pc_nx;
    logic [31:0] hold_instr, hold_instr_nx;
    logic [31:0] hold_pc4, hold_pc4_nx;
    logic        kill, kill_nx;
    logic        req_nx;
    logic [31:0] instr_nx, pc4_nx;
    logic        valid_nx;

    logic        stall;
    logic        redirect;
    logic        ready;
    logic [31:0] tgt;
    logic [31:0] pc_inc;

    assign stall     = reg_lock | reg_lock_if;
    // A global freeze blocks redirects; the ID stage re-presents them later.
    assign redirect  = jump_or_branch & ~reg_lock;
    // A response only counts while a request is actually on the bus.
    assign ready     = imem_ready & imem_req;
    assign tgt       = target & ~32'd3;
    assign pc_inc    = pc + 32'd4;
    assign imem_addr = pc;

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        redir_pc_nx   = redir_pc;
        hold_instr_nx = hold_instr;
        hold_pc4_nx   = hold_pc4;
        kill_nx       = kill;
        instr_nx      = instruction;
        pc4_nx        = pc_plus_four;
        valid_nx      = if_valid;

        case (state)
            S_REQ: begin
                if (redirect) begin
                    instr_nx = NOP_INSTR;
                    valid_nx = 1'b0;
                    if (ready || !imem_req) begin
                        pc_nx   = tgt;
                        kill_nx = 1'b0;
                    end else begin
                        // Request in flight: keep the address stable and
                        // drop the response when it finally arrives.
                        redir_pc_nx = tgt;
                        kill_nx     = 1'b1;
                    end
                end else if (ready && kill) begin
                    kill_nx = 1'b0;
                    pc_nx   = redir_pc;
                    if (!stall) begin
                        instr_nx = NOP_INSTR;
                        valid_nx = 1'b0;
                    end
                end else if (ready && !stall) begin
                    instr_nx = imem_rdata;
                    pc4_nx   = pc_inc;
                    valid_nx = 1'b1;
                    pc_nx    = pc_inc;
                end else if (ready) begin
                    // Stalled: park the word so it is never lost.
                    hold_instr_nx = imem_rdata;
                    hold_pc4_nx   = pc_inc;
                    state_nx      = S_HOLD;
                end else if (!stall) begin
                    instr_nx = NOP_INSTR;
                    valid_nx = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    instr_nx = NOP_INSTR;
                    valid_nx = 1'b0;
                    pc_nx    = tgt;
                    state_nx = S_REQ;
                end else if (!stall) begin
                    instr_nx = hold_instr;
                    pc4_nx   = hold_pc4;
                    valid_nx = 1'b1;
                    pc_nx    = hold_pc4;
                    state_nx = S_REQ;
                end
            end
            default: begin
                state_nx = S_REQ;
            end
        endcase

        // Registered request: low during reset, rises on the first edge after.
        req_nx = (state_nx == S_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            redir_pc     <= 32'd0;
            hold_instr   <= NOP_INSTR;
            hold_pc4     <= 32'd0;
            kill         <= 1'b0;
            imem_req     <= 1'b0;
            instruction  <= NOP_INSTR;
            pc_plus_four <= 32'd0;
            if_valid     <= 1'b0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            redir_pc     <= redir_pc_nx;
            hold_instr   <= hold_instr_nx;
            hold_pc4     <= hold_pc4_nx;
            kill         <= kill_nx;
            imem_req     <= req_nx;
            instruction  <= instr_nx;
            pc_plus_four <= pc4_nx;
            if_valid     <= valid_nx;
        end
    end

`ifdef IFETCH_PERF_EN
    logic fetch_inc;

    // A real word enters IF/ID either straight from imem or from the buffer.
    assign fetch_inc = ((state == S_REQ) && ready && !kill && !redirect && !stall) ||
                       ((state == S_HOLD) && !redirect && !stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count  <= 32'd0;
            stall_count  <= 32'd0;
            squash_count <= 32'd0;
        end else begin
            if (fetch_inc) fetch_count  <= fetch_count + 32'd1;
            if (stall)     stall_count  <= stall_count + 32'd1;
            if (redirect)  squash_count <= squash_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_i_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_i_fetch
// Description : Self-checking bench for i_fetch: directed scenarios plus a
//               randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i_fetch;

    localparam logic [31:0] NOP = 32'h0000_0015;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        reg_lock = 1'b0;
    logic        reg_lock_if = 1'b0;
    logic        jump_or_branch = 1'b0;
    logic [31:0] target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_plus_four;
    logic        if_valid;
    logic [31:0] rd_xor = 32'd0;

    logic        req2;
    logic [31:0] addr2;
    logic        ready2 = 1'b0;
    logic [31:0] instr2;
    logic [31:0] pc4_2;
    logic        valid2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // imem behavioural model: word content is a fixed function of address.
    assign imem_rdata = imem_addr ^ rd_xor;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count, stall_count, squash_count;
    logic [31:0] fc2, sc2, qc2;
`endif

    i_fetch dut (
        .clk(clk), .rst_n(rst_n), .reg_lock(reg_lock), .reg_lock_if(reg_lock_if),
        .jump_or_branch(jump_or_branch), .target(target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instruction(instruction),
        .pc_plus_four(pc_plus_four), .if_valid(if_valid)
`ifdef IFETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count), .squash_count(squash_count)
`endif
    );

    i_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .reg_lock(1'b0), .reg_lock_if(1'b0),
        .jump_or_branch(1'b0), .target(32'd0),
        .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2),
        .imem_rdata(addr2), .instruction(instr2),
        .pc_plus_four(pc4_2), .if_valid(valid2)
`ifdef IFETCH_PERF_EN
        , .fetch_count(fc2), .stall_count(sc2), .squash_count(qc2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reg_lock = 0; reg_lock_if = 0; jump_or_branch = 0; target = 0;
        imem_ready = 0; ready2 = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rd_xor = 0;
        reg_lock = 0; reg_lock_if = 0; jump_or_branch = 0; imem_ready = 0;
        rst_n = 0;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", imem_req); end
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instr got %0h exp %0h", instruction, NOP); end
        checks++; if (pc_plus_four !== 32'd0) begin errors++; $display("FAIL reset_pc4 got %0h exp 0", pc_plus_four); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", if_valid); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %0h exp 0", imem_addr); end
        rst_n = 1;
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL release_req got %0h exp 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL first_req got %0h/%0h exp 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        imem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instruction !== 32'(i * 4) || pc_plus_four !== 32'(i * 4 + 4) || if_valid !== 1'b1 || imem_addr !== 32'(i * 4 + 4)) begin
                errors++;
                $display("FAIL seq_%0d got ins=%0h pc4=%0h v=%0h addr=%0h exp ins=%0h pc4=%0h v=1 addr=%0h",
                         i, instruction, pc_plus_four, if_valid, imem_addr, i * 4, i * 4 + 4, i * 4 + 4);
            end
        end
        imem_ready = 0;
    endtask

    task automatic test_stall_hold();
        do_reset();
        tick();
        imem_ready = 1;
        tick(); tick();
        reg_lock_if = 1;
        tick();
        imem_ready = 0;
        checks++; if (instruction !== 32'h4 || pc_plus_four !== 32'h8 || imem_req !== 1'b0) begin errors++; $display("FAIL hold_enter got ins=%0h pc4=%0h req=%0h exp 4/8/0", instruction, pc_plus_four, imem_req); end
        tick(); tick();
        checks++; if (instruction !== 32'h4 || if_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL hold_keep got ins=%0h v=%0h req=%0h exp 4/1/0", instruction, if_valid, imem_req); end
        reg_lock_if = 0;
        tick();
        checks++; if (instruction !== 32'h8 || pc_plus_four !== 32'hC || if_valid !== 1'b1) begin errors++; $display("FAIL hold_release got ins=%0h pc4=%0h v=%0h exp 8/c/1", instruction, pc_plus_four, if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL hold_next_addr got req=%0h addr=%0h exp 1/c", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_ready();
        imem_ready = 1; jump_or_branch = 1; target = 32'h100;
        tick();
        jump_or_branch = 0;
        checks++; if (instruction !== NOP || if_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got ins=%0h v=%0h exp %0h/0", instruction, if_valid, NOP); end
        checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL redir_addr got addr=%0h req=%0h exp 100/1", imem_addr, imem_req); end
        tick();
        checks++; if (instruction !== 32'h100 || pc_plus_four !== 32'h104 || if_valid !== 1'b1) begin errors++; $display("FAIL redir_first got ins=%0h pc4=%0h v=%0h exp 100/104/1", instruction, pc_plus_four, if_valid); end
        imem_ready = 0;
    endtask

    task automatic test_redirect_pending();
        imem_ready = 1; jump_or_branch = 1; target = 32'h20;
        tick();
        imem_ready = 0; target = 32'h43;
        tick();
        jump_or_branch = 0;
        checks++; if (imem_addr !== 32'h20 || if_valid !== 1'b0) begin errors++; $display("FAIL pend_hold_addr got addr=%0h v=%0h exp 20/0", imem_addr, if_valid); end
        tick(); tick();
        checks++; if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin errors++; $display("FAIL pend_stable got addr=%0h req=%0h exp 20/1", imem_addr, imem_req); end
        imem_ready = 1;
        tick();
        checks++; if (instruction !== NOP || if_valid !== 1'b0) begin errors++; $display("FAIL pend_drop got ins=%0h v=%0h exp %0h/0", instruction, if_valid, NOP); end
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL pend_next got addr=%0h exp 40", imem_addr); end
        tick();
        checks++; if (instruction !== 32'h40 || pc_plus_four !== 32'h44 || if_valid !== 1'b1) begin errors++; $display("FAIL pend_target got ins=%0h pc4=%0h v=%0h exp 40/44/1", instruction, pc_plus_four, if_valid); end
        imem_ready = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got req=%0h addr=%0h exp 1/fffffffc", req2, addr2); end
        ready2 = 1;
        tick();
        checks++; if (instr2 !== 32'hFFFF_FFFC || pc4_2 !== 32'd0 || addr2 !== 32'd0) begin errors++; $display("FAIL wrap_pc4 got ins=%0h pc4=%0h addr=%0h exp fffffffc/0/0", instr2, pc4_2, addr2); end
        tick();
        checks++; if (instr2 !== 32'd0 || pc4_2 !== 32'd4 || valid2 !== 1'b1) begin errors++; $display("FAIL wrap_after got ins=%0h pc4=%0h v=%0h exp 0/4/1", instr2, pc4_2, valid2); end
        ready2 = 0;
    endtask

    task automatic test_reset_mid_hold();
        rd_xor = 0;
        do_reset();
        tick();
        imem_ready = 1;
        tick();
        reg_lock_if = 1;
        tick();
        imem_ready = 0;
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1) begin errors++; $display("FAIL mid_hold_pre got req=%0h v=%0h exp 0/1", imem_req, if_valid); end
`ifdef IFETCH_PERF_EN
        checks++; if (fetch_count !== 32'd1 || stall_count !== 32'd1) begin errors++; $display("FAIL perf_pre got f=%0h s=%0h exp 1/1", fetch_count, stall_count); end
`endif
        #2;
        rst_n = 0;
        #1;
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || instruction !== NOP || imem_addr !== 32'd0) begin errors++; $display("FAIL mid_reset got req=%0h v=%0h ins=%0h addr=%0h exp 0/0/%0h/0", imem_req, if_valid, instruction, imem_addr, NOP); end
`ifdef IFETCH_PERF_EN
        checks++; if (fetch_count !== 0 || stall_count !== 0 || squash_count !== 0) begin errors++; $display("FAIL perf_reset got f=%0h s=%0h q=%0h exp 0", fetch_count, stall_count, squash_count); end
`endif
        reg_lock_if = 0;
        tick();
        rst_n = 1;
    endtask

    // Reference model: fetch pointer, a queue of parked words and a queue
    // holding the latest deferred redirect target.
    task automatic test_random();
        logic [31:0] m_pc, m_ins, m_pc4;
        logic        m_val, m_started;
        logic [63:0] held_q[$];
        logic [31:0] redir_q[$];
        int unsigned m_fc, m_sc, m_qc;
        rd_xor = 32'h5A5A_0000;
        do_reset();
        m_pc = 32'd0; m_ins = NOP; m_pc4 = 32'd0; m_val = 1'b0; m_started = 1'b0;
        held_q.delete(); redir_q.delete();
        m_fc = 0; m_sc = 0; m_qc = 0;
        for (int n = 0; n < 1500; n++) begin
            logic        lk, lkif, jb, rdy, stl, rdr, exp_req;
            logic [31:0] tg, word;
            logic [63:0] ent;
            exp_req = m_started && (held_q.size() == 0);
            lk   = ($urandom_range(0, 9) == 0);
            lkif = ($urandom_range(0, 6) == 0);
            jb   = ($urandom_range(0, 9) == 0);
            tg   = $urandom;
            rdy  = exp_req && ($urandom_range(0, 9) < 6);
            reg_lock = lk; reg_lock_if = lkif; jump_or_branch = jb; target = tg; imem_ready = rdy;
            stl = lk | lkif;
            rdr = jb && !lk;
            if (stl) m_sc++;
            if (rdr) m_qc++;
            if (held_q.size() != 0) begin
                if (rdr) begin
                    m_ins = NOP; m_val = 1'b0; held_q.delete(); m_pc = tg & ~32'd3;
                end else if (!stl) begin
                    ent = held_q.pop_front();
                    m_ins = ent[63:32]; m_pc4 = ent[31:0]; m_val = 1'b1; m_fc++; m_pc = m_pc4;
                end
            end else if (rdr) begin
                m_ins = NOP; m_val = 1'b0; redir_q.delete();
                if (rdy || !m_started) m_pc = tg & ~32'd3;
                else redir_q.push_back(tg & ~32'd3);
            end else if (rdy && redir_q.size() != 0) begin
                m_pc = redir_q.pop_front();
                if (!stl) begin m_ins = NOP; m_val = 1'b0; end
            end else if (rdy) begin
                word = m_pc ^ rd_xor;
                if (stl) held_q.push_back({word, m_pc + 32'd4});
                else begin
                    m_ins = word; m_pc4 = m_pc + 32'd4; m_val = 1'b1; m_fc++; m_pc = m_pc + 32'd4;
                end
            end else if (!stl) begin
                m_ins = NOP; m_val = 1'b0;
            end
            m_started = 1'b1;
            tick();
            exp_req = held_q.size() == 0;
            checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req cyc %0d got %0h exp %0h", n, imem_req, exp_req); end
            if (exp_req) begin
                checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr cyc %0d got %0h exp %0h", n, imem_addr, m_pc); end
            end
            checks++; if (instruction !== m_ins || if_valid !== m_val) begin errors++; $display("FAIL rnd_ifid cyc %0d got %0h/%0h exp %0h/%0h", n, instruction, if_valid, m_ins, m_val); end
            checks++; if (pc_plus_four !== m_pc4) begin errors++; $display("FAIL rnd_pc4 cyc %0d got %0h exp %0h", n, pc_plus_four, m_pc4); end
`ifdef IFETCH_PERF_EN
            checks++; if (fetch_count !== m_fc || stall_count !== m_sc || squash_count !== m_qc) begin errors++; $display("FAIL rnd_perf cyc %0d got %0h/%0h/%0h exp %0h/%0h/%0h", n, fetch_count, stall_count, squash_count, m_fc, m_sc, m_qc); end
`endif
        end
        reg_lock = 0; reg_lock_if = 0; jump_or_branch = 0; imem_ready = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_ready();
        test_redirect_pending();
        test_wrap();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
